pipe_credit_rx: RTL and testbench
=================================

Name: pipe_credit_rx

Overview:
- Receiving end of a fixed-latency, no-backpressure pipeline built from single-bit and multi-bit delay stages.
- A producer launches words into an N-stage delay pipe. Those stages cannot stall, so this block grants launch credits up front and lands every arriving word in a small FWFT FIFO.
- The consumer then drains the FIFO with a valid/ready handshake.
- Purpose: lets a stallable consumer sit behind a non-stallable pipeline in the core without losing in-flight data.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, FIFO entries and total credits. Must be a power of 2 and ≥2. Must be ≥ round-trip latency for full throughput.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- i_issue  input  1  producer launches one word into the delay pipe this cycle.
- o_credit_avail  output  1  at least one credit free; i_issue is legal only when this is high.
- i_arr_valid  input  1  word arriving from the delay pipe output.
- i_arr_data  input  WIDTH  arriving word.
- o_valid  output  1  FIFO head valid.
- o_data  output  WIDTH  FIFO head word.
- i_ready  input  1  consumer accepts head; pop = o_valid & i_ready.
- o_count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- o_error  output  1  sticky protocol error flag.

Behaviour:
- Reset values:
  - credit counter = DEPTH, so o_credit_avail = 1.
  - FIFO empty: o_valid = 0, o_count = 0.
  - o_error = 0; o_data value is don't-care.
  - Pointers = 0.
  - Arrivals and issues presented during the reset cycle are ignored.
- Credit counter:
  - Decrements on an accepted issue.
  - Increments on pop.
  - Issue and pop in the same cycle leave it unchanged.
  - o_credit_avail = (credits != 0), decoded from the register. A credit freed by a pop is visible the next cycle.
- Illegal issue: i_issue while credits == 0 → counter unchanged, o_error set next cycle.
- Arrival:
  - Writes mem[wr_ptr] and advances wr_ptr modulo DEPTH.
  - Arrival at cycle t into an empty FIFO → o_valid = 1 and o_data = that word at t+1 (one-cycle landing latency, no combinational in→out path).
- Pop: advances rd_ptr; o_data shows the next entry the following cycle. Pop on an empty FIFO cannot occur because o_valid = 0.
- Occupancy: o_count +1 on arrival only, −1 on pop only, unchanged when both happen.
- Full boundary:
  - Arrival while o_count == DEPTH and no pop that cycle → word dropped, pointers unchanged, o_error set.
  - Arrival with a pop in the same cycle when full → legal, and count stays at DEPTH.
- Invariant under legal use: credits + o_count + words in flight == DEPTH.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are taken from o_count, not from pointer compare.
- o_error:
  - Sticky until reset; has no effect on data flow.
  - Also set if the credit counter would exceed DEPTH (pop with credits == DEPTH, meaning an arrival without an issue).
- Reset mid-operation:
  - FIFO contents and credits are discarded.
  - The upstream delay pipe must use its reset-clearing variant so no stale valid arrives after reset. Any such arrival is treated as a normal arrival.

Decomposition:
- Package pipe_pkg: function for counter width, $clog2(DEPTH+1).
- Natural sub-module credit_ctr: up/down saturating counter with illegal-op flag, reused for credits and occupancy.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset, then idle → o_credit_avail = 1, o_valid = 0, o_count = 0, o_error = 0 for 10 cycles.
- DEPTH = 4, 2-cycle external delay pipe: issue 0xA, 0xB, 0xC, 0xD on consecutive cycles with i_ready = 0 → o_credit_avail = 0 after the 4th issue; o_count = 4; o_data = 0xA; o_error = 0.
- Continue the previous case: raise i_ready for 4 cycles → o_data sequence 0xA, 0xB, 0xC, 0xD; o_credit_avail = 1 the cycle after the first pop; o_count returns to 0.
- Full throughput, i_ready = 1, issue every cycle for 20 words 0..19 → all 20 delivered in order, no gap after the initial fill, o_error = 0, pointers wrap 5×.
- i_issue while credits = 0 → o_error = 1 next cycle and stays high; credits remain 0.
- Reset asserted with o_count = 3 → next cycle o_count = 0, o_valid = 0, o_credit_avail = 1, o_error = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe credit receiver: counter sizing for values 0..DEPTH.
package pipe_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_credit_rx_if.sv
// Producer/consumer-facing signals of pipe_credit_rx, grouped with DUT-side (slave) and driver-side (master) views.
interface pipe_credit_rx_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = cnt_w(DEPTH);

    logic             i_issue;
    logic             o_credit_avail;
    logic             i_arr_valid;
    logic [WIDTH-1:0] i_arr_data;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             i_ready;
    logic [CW-1:0]    o_count;
    logic             o_error;

    modport slave (
        input  i_issue, i_arr_valid, i_arr_data, i_ready,
        output o_credit_avail, o_valid, o_data, o_count, o_error
    );

    modport master (
        output i_issue, i_arr_valid, i_arr_data, i_ready,
        input  o_credit_avail, o_valid, o_data, o_count, o_error
    );
endinterface

// File: rtl/credit_ctr.sv
// Up/down counter bounded to 0..MAX; an increment past MAX or a decrement below 0 is
// refused and reported on err for that cycle.
module credit_ctr
    import pipe_pkg::*;
#(
    parameter int MAX     = 4,
    parameter int W       = cnt_w(MAX),
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         err
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         inc_ok, dec_ok;

    // A simultaneous legal decrement makes room, so inc at MAX is fine then.
    always_comb begin
        dec_ok = dec && (cnt_q != '0);
        inc_ok = inc && ((cnt_q != W'(MAX)) || dec_ok);
        cnt_d  = cnt_q;
        case ({inc_ok, dec_ok})
            2'b10:   cnt_d = cnt_q + W'(1);
            2'b01:   cnt_d = cnt_q - W'(1);
            default: cnt_d = cnt_q;
        endcase
        err = (dec && !dec_ok) || (inc && !inc_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_credit_rx.sv
// Receiver for a non-stallable delay pipe: hands out launch credits and lands every
// arriving word in a small first-word-fall-through FIFO drained by valid/ready.
module pipe_credit_rx
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    pipe_credit_rx_if.slave bus
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0]    credits, occ;
    logic             cred_err, occ_err;
    logic             pop, full, arr_acc;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem [DEPTH];

    assign pop     = bus.o_valid & bus.i_ready;
    assign full    = (occ == CW'(DEPTH));
    assign arr_acc = bus.i_arr_valid & (~full | pop);

    // Credits: issue consumes one, pop returns one.
    credit_ctr #(.MAX(DEPTH), .W(CW), .RST_VAL(DEPTH)) u_credits (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .dec   (bus.i_issue),
        .cnt   (credits),
        .err   (cred_err)
    );

    // Occupancy: full/empty come from here, never from pointer comparison.
    credit_ctr #(.MAX(DEPTH), .W(CW), .RST_VAL(0)) u_occ (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.i_arr_valid),
        .dec   (pop),
        .cnt   (occ),
        .err   (occ_err)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (arr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        err_d = err_q | cred_err | occ_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Storage carries no reset; a stale entry is never visible because occ gates o_valid.
    always_ff @(posedge clk) begin
        if (arr_acc) mem[wr_ptr_q] <= bus.i_arr_data;
    end

    assign bus.o_credit_avail = (credits != '0);
    assign bus.o_valid        = (occ != '0);
    assign bus.o_data         = mem[rd_ptr_q];
    assign bus.o_count        = occ;
    assign bus.o_error        = err_q;
endmodule

// File: tb/tb_pipe_credit_rx.sv
// Directed bench for pipe_credit_rx with DEPTH=4 behind a 2-cycle external delay pipe.
module tb_pipe_credit_rx;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic        pv [2];
    logic [31:0] pd [2];

    pipe_credit_rx_if #(.WIDTH(32), .DEPTH(4)) bus ();

    pipe_credit_rx #(.WIDTH(32), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: present inputs, take the edge, advance the delay pipe, settle #1.
    task automatic cycle(input logic iss, input logic [31:0] d, input logic rdy);
        bus.i_issue     = iss;
        bus.i_arr_valid = pv[1];
        bus.i_arr_data  = pd[1];
        bus.i_ready     = rdy;
        @(posedge clk);
        pv[1] = pv[0];
        pd[1] = pd[0];
        pv[0] = iss;
        pd[0] = d;
        if (rst) begin
            pv[0] = 1'b0;
            pv[1] = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            checks += 4;
            if (bus.o_credit_avail !== 1'b1) begin failures++; $display("FAIL reset_avail cyc=%0d got=%b exp=1", i, bus.o_credit_avail); end
            if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, bus.o_valid); end
            if (bus.o_count !== 3'd0) begin failures++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, bus.o_count); end
            if (bus.o_error !== 1'b0) begin failures++; $display("FAIL reset_error cyc=%0d got=%b exp=0", i, bus.o_error); end
            cycle(1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_fill();
        do_reset();
        cycle(1'b1, 32'hA, 1'b0);
        cycle(1'b1, 32'hB, 1'b0);
        cycle(1'b1, 32'hC, 1'b0);
        cycle(1'b1, 32'hD, 1'b0);
        checks++;
        if (bus.o_credit_avail !== 1'b0) begin failures++; $display("FAIL fill_avail got=%b exp=0", bus.o_credit_avail); end
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        checks += 4;
        if (bus.o_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", bus.o_count); end
        if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL fill_valid got=%b exp=1", bus.o_valid); end
        if (bus.o_data !== 32'hA) begin failures++; $display("FAIL fill_data got=%0h exp=a", bus.o_data); end
        if (bus.o_error !== 1'b0) begin failures++; $display("FAIL fill_error got=%b exp=0", bus.o_error); end
    endtask

    task automatic test_drain();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC; exp_d[3] = 32'hD;
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL drain_valid idx=%0d got=%b exp=1", i, bus.o_valid); end
            if (bus.o_data !== exp_d[i]) begin failures++; $display("FAIL drain_data idx=%0d got=%0h exp=%0h", i, bus.o_data, exp_d[i]); end
            cycle(1'b0, 32'h0, 1'b1);
            if (i == 0) begin
                checks++;
                if (bus.o_credit_avail !== 1'b1) begin failures++; $display("FAIL drain_avail got=%b exp=1", bus.o_credit_avail); end
            end
        end
        checks += 3;
        if (bus.o_count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", bus.o_count); end
        if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.o_valid); end
        if (bus.o_error !== 1'b0) begin failures++; $display("FAIL drain_error got=%b exp=0", bus.o_error); end
    endtask

    task automatic test_throughput();
        logic [31:0] rx_d [$];
        int          rx_c [$];
        int          n_iss;
        logic        iss;
        do_reset();
        n_iss = 0;
        for (int c = 0; c < 30; c++) begin
            iss = (n_iss < 20);
            if (iss) begin
                checks++;
                if (bus.o_credit_avail !== 1'b1) begin failures++; $display("FAIL thr_avail cyc=%0d got=%b exp=1", c, bus.o_credit_avail); end
            end
            if (bus.o_valid === 1'b1) begin
                rx_d.push_back(bus.o_data);
                rx_c.push_back(c);
            end
            cycle(iss, 32'(n_iss), 1'b1);
            if (iss) n_iss++;
        end
        checks++;
        if (rx_d.size() != 20) begin failures++; $display("FAIL thr_size got=%0d exp=20", rx_d.size()); end
        for (int i = 0; i < rx_d.size() && i < 20; i++) begin
            checks += 2;
            if (rx_d[i] !== 32'(i)) begin failures++; $display("FAIL thr_data idx=%0d got=%0h exp=%0h", i, rx_d[i], i); end
            if (rx_c[i] != i + 3) begin failures++; $display("FAIL thr_cycle idx=%0d got=%0d exp=%0d", i, rx_c[i], i + 3); end
        end
        checks += 2;
        if (bus.o_error !== 1'b0) begin failures++; $display("FAIL thr_error got=%b exp=0", bus.o_error); end
        if (bus.o_count !== 3'd0) begin failures++; $display("FAIL thr_count got=%0d exp=0", bus.o_count); end
    endtask

    task automatic test_illegal_issue();
        do_reset();
        cycle(1'b1, 32'hA, 1'b0);
        cycle(1'b1, 32'hB, 1'b0);
        cycle(1'b1, 32'hC, 1'b0);
        cycle(1'b1, 32'hD, 1'b0);
        checks += 2;
        if (bus.o_credit_avail !== 1'b0) begin failures++; $display("FAIL ill_avail_pre got=%b exp=0", bus.o_credit_avail); end
        if (bus.o_error !== 1'b0) begin failures++; $display("FAIL ill_error_pre got=%b exp=0", bus.o_error); end
        cycle(1'b1, 32'hE, 1'b0);
        checks += 2;
        if (bus.o_error !== 1'b1) begin failures++; $display("FAIL ill_error got=%b exp=1", bus.o_error); end
        if (bus.o_credit_avail !== 1'b0) begin failures++; $display("FAIL ill_avail got=%b exp=0", bus.o_credit_avail); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            checks += 2;
            if (bus.o_error !== 1'b1) begin failures++; $display("FAIL ill_sticky cyc=%0d got=%b exp=1", i, bus.o_error); end
            if (bus.o_credit_avail !== 1'b0) begin failures++; $display("FAIL ill_avail_hold cyc=%0d got=%b exp=0", i, bus.o_credit_avail); end
        end
        checks += 2;
        if (bus.o_count !== 3'd4) begin failures++; $display("FAIL ill_count got=%0d exp=4", bus.o_count); end
        if (bus.o_data !== 32'hA) begin failures++; $display("FAIL ill_head got=%0h exp=a", bus.o_data); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 32'h0, 1'b1);
        checks += 2;
        if (bus.o_count !== 3'd3) begin failures++; $display("FAIL mid_count_pre got=%0d exp=3", bus.o_count); end
        if (bus.o_data !== 32'hB) begin failures++; $display("FAIL mid_head_pre got=%0h exp=b", bus.o_data); end
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        checks += 4;
        if (bus.o_count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", bus.o_count); end
        if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.o_valid); end
        if (bus.o_credit_avail !== 1'b1) begin failures++; $display("FAIL mid_avail got=%b exp=1", bus.o_credit_avail); end
        if (bus.o_error !== 1'b0) begin failures++; $display("FAIL mid_error got=%b exp=0", bus.o_error); end
    endtask

    task automatic test_spurious_arrival();
        pv[1] = 1'b1;
        pd[1] = 32'h55;
        cycle(1'b0, 32'h0, 1'b0);
        checks += 3;
        if (bus.o_count !== 3'd1) begin failures++; $display("FAIL spur_count got=%0d exp=1", bus.o_count); end
        if (bus.o_data !== 32'h55) begin failures++; $display("FAIL spur_data got=%0h exp=55", bus.o_data); end
        if (bus.o_error !== 1'b0) begin failures++; $display("FAIL spur_error_pre got=%b exp=0", bus.o_error); end
        cycle(1'b0, 32'h0, 1'b1);
        checks += 3;
        if (bus.o_error !== 1'b1) begin failures++; $display("FAIL spur_error got=%b exp=1", bus.o_error); end
        if (bus.o_count !== 3'd0) begin failures++; $display("FAIL spur_count_post got=%0d exp=0", bus.o_count); end
        if (bus.o_credit_avail !== 1'b1) begin failures++; $display("FAIL spur_avail got=%b exp=1", bus.o_credit_avail); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        pv[0]           = 1'b0;
        pv[1]           = 1'b0;
        pd[0]           = '0;
        pd[1]           = '0;
        bus.i_issue     = 1'b0;
        bus.i_arr_valid = 1'b0;
        bus.i_arr_data  = '0;
        bus.i_ready     = 1'b0;

        test_reset();
        test_fill();
        test_drain();
        test_throughput();
        test_illegal_issue();
        test_reset_mid();
        test_spurious_arrival();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
